// File: rtl/double_to_sig16b_conv.sv
// Four-stage binary64 to saturated signed 16-bit converter, triggered once per
// sampling period when the sampling counter reaches zero.
module double_to_sig16b_conv (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        enable,
  input  logic [12:0] sampling_cycle_counter,
  input  logic [63:0] double,
  output logic [15:0] sig16b
);

  typedef enum logic [1:0] {
    CLS_ZERO    = 2'd0,
    CLS_POS_SAT = 2'd1,
    CLS_NEG_SAT = 2'd2,
    CLS_NUM     = 2'd3
  } cls_t;

  // Stage 1: capture
  logic        s1_v_q, s1_v_d;
  logic [63:0] s1_q, s1_d;

  // Stage 2: classification
  logic        s2_v_q;
  cls_t        s2_cls_q, s2_cls_d;
  logic        s2_sign_q;
  logic [3:0]  s2_e_q, s2_e_d;
  logic [51:0] s2_frac_q;

  // Stage 3: magnitude
  logic        s3_v_q;
  cls_t        s3_cls_q;
  logic        s3_sign_q;
  logic [14:0] s3_mag_q, s3_mag_d;

  // Stage 4: output register
  logic [15:0] sig16b_q, sig16b_d;

  logic        capture;
  logic [10:0] exp_w;
  logic [51:0] frac_w;
  logic [5:0]  shamt;

  assign capture = enable && (sampling_cycle_counter == '0);
  assign exp_w   = s1_q[62:52];
  assign frac_w  = s1_q[51:0];

  always_comb begin
    s1_v_d = capture;
    s1_d   = capture ? double : s1_q;
  end

  // Only e in [0,14] reaches the magnitude stage; since 1023 = 15 mod 16,
  // the low four bits of exp-1023 are exp[3:0]+1.
  always_comb begin
    s2_e_d = exp_w[3:0] + 4'd1;
    if (exp_w == '1) begin
      if (frac_w != '0)  s2_cls_d = CLS_ZERO;
      else if (s1_q[63]) s2_cls_d = CLS_NEG_SAT;
      else               s2_cls_d = CLS_POS_SAT;
    end else if (exp_w < 11'd1023) begin
      s2_cls_d = CLS_ZERO;
    end else if (exp_w >= 11'd1038) begin
      s2_cls_d = s1_q[63] ? CLS_NEG_SAT : CLS_POS_SAT;
    end else begin
      s2_cls_d = CLS_NUM;
    end
  end

  // Shifting the full mantissa (hidden bit included) by 52-e yields
  // (1<<e) | (fraction >> (52-e)), truncated toward zero.
  always_comb begin
    shamt    = 6'd52 - {2'b00, s2_e_q};
    s3_mag_d = 15'({1'b1, s2_frac_q} >> shamt);
  end

  always_comb begin
    sig16b_d = sig16b_q;
    if (s3_v_q) begin
      unique case (s3_cls_q)
        CLS_ZERO:    sig16b_d = '0;
        CLS_POS_SAT: sig16b_d = 16'h7FFF;
        CLS_NEG_SAT: sig16b_d = 16'h8000;
        CLS_NUM:     sig16b_d = s3_sign_q ? (16'd0 - {1'b0, s3_mag_q}) : {1'b0, s3_mag_q};
        default:     sig16b_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_q      <= '0;
      s2_v_q    <= 1'b0;
      s2_cls_q  <= CLS_ZERO;
      s2_sign_q <= 1'b0;
      s2_e_q    <= '0;
      s2_frac_q <= '0;
      s3_v_q    <= 1'b0;
      s3_cls_q  <= CLS_ZERO;
      s3_sign_q <= 1'b0;
      s3_mag_q  <= '0;
      sig16b_q  <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_q      <= s1_d;
      s2_v_q    <= s1_v_q;
      s2_cls_q  <= s2_cls_d;
      s2_sign_q <= s1_q[63];
      s2_e_q    <= s2_e_d;
      s2_frac_q <= frac_w;
      s3_v_q    <= s2_v_q;
      s3_cls_q  <= s2_cls_q;
      s3_sign_q <= s2_sign_q;
      s3_mag_q  <= s3_mag_d;
      sig16b_q  <= sig16b_d;
    end
  end

  assign sig16b = sig16b_q;

endmodule

// File: tb/tb_double_to_sig16b_conv.sv
// Directed self-checking bench for double_to_sig16b_conv.
module tb_double_to_sig16b_conv;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [12:0] cnt;
  logic [63:0] dbl;
  logic [15:0] sig16b;

  int checks;
  int fails;

  double_to_sig16b_conv dut (
    .clk_operation          (clk),
    .rst                    (rst),
    .enable                 (enable),
    .sampling_cycle_counter (cnt),
    .double                 (dbl),
    .sig16b                 (sig16b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one capture edge; returns at the falling edge after the capture.
  task automatic pulse_capture(input logic [63:0] v);
    @(negedge clk);
    enable = 1'b1;
    cnt    = 13'd0;
    dbl    = v;
    @(negedge clk);
    cnt    = 13'd5;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b1;
    cnt    = 13'd0;
    dbl    = 64'h3FF0000000000000;
    repeat (2) @(negedge clk);
    checks++;
    if (sig16b !== 16'h0000) begin
      fails++;
      $display("FAIL reset_value: got %h expected 0000", sig16b);
    end
    rst = 1'b0;
    cnt = 13'd5;
    repeat (4) @(negedge clk);
    checks++;
    if (sig16b !== 16'h0000) begin
      fails++;
      $display("FAIL reset_over_capture: got %h expected 0000", sig16b);
    end
  endtask

  task automatic test_latency;
    logic [15:0] exp_seq [4];
    exp_seq = '{16'h0000, 16'h0000, 16'h0000, 16'h0001};
    pulse_capture(64'h3FF0000000000000);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (sig16b !== exp_seq[i]) begin
        fails++;
        $display("FAIL latency_edge_N+%0d: got %h expected %h", i, sig16b, exp_seq[i]);
      end
    end
  endtask

  task automatic test_conversions;
    logic [63:0] vin  [14];
    logic [15:0] vexp [14];
    vin  = '{64'hC006000000000000, 64'h3FE0000000000000, 64'h40E3880000000000,
             64'hC0E0000000000000, 64'h40DFFFC000000000, 64'hFFF0000000000000,
             64'h7FF8000000000000, 64'h7FF0000000000000, 64'h0000000000000001,
             64'hBFF0000000000000, 64'h408F400000000000, 64'h400C000000000000,
             64'h8000000000000000, 64'h4059000000000000};
    vexp = '{16'hFFFE, 16'h0000, 16'h7FFF,
             16'h8000, 16'h7FFF, 16'h8000,
             16'h0000, 16'h7FFF, 16'h0000,
             16'hFFFF, 16'h03E8, 16'h0003,
             16'h0000, 16'h0064};
    for (int i = 0; i < 14; i++) begin
      pulse_capture(vin[i]);
      repeat (3) @(negedge clk);
      checks++;
      if (sig16b !== vexp[i]) begin
        fails++;
        $display("FAIL convert_%h: got %h expected %h", vin[i], sig16b, vexp[i]);
      end
    end
  endtask

  task automatic test_hold;
    @(negedge clk);
    enable = 1'b0;
    cnt    = 13'd0;
    dbl    = 64'h3FF0000000000000;
    repeat (5) @(negedge clk);
    checks++;
    if (sig16b !== 16'h0064) begin
      fails++;
      $display("FAIL hold_enable_low: got %h expected 0064", sig16b);
    end
    enable = 1'b1;
    cnt    = 13'd5;
    dbl    = 64'h401C000000000000;
    repeat (5) @(negedge clk);
    checks++;
    if (sig16b !== 16'h0064) begin
      fails++;
      $display("FAIL hold_counter_nonzero: got %h expected 0064", sig16b);
    end
    for (int i = 0; i < 4; i++) begin
      cnt = 13'(i + 1);
      dbl = 64'hC0E0000000000000 ^ 64'(i);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sig16b !== 16'h0064) begin
      fails++;
      $display("FAIL hold_double_changes: got %h expected 0064", sig16b);
    end
  endtask

  task automatic test_enable_drop_inflight;
    pulse_capture(64'h3FF0000000000000);
    enable = 1'b0;
    cnt    = 13'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (sig16b !== 16'h0001) begin
      fails++;
      $display("FAIL enable_drop_inflight: got %h expected 0001", sig16b);
    end
  endtask

  task automatic test_reset_inflight;
    pulse_capture(64'h408F400000000000);
    enable = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sig16b !== 16'h0000) begin
        fails++;
        $display("FAIL reset_inflight_cycle%0d: got %h expected 0000", i, sig16b);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_seq [3];
    exp_seq = '{16'h0000, 16'h0007, 16'hFFF9};
    @(negedge clk);
    enable = 1'b1;
    cnt    = 13'd0;
    dbl    = 64'h401C000000000000;
    @(negedge clk);
    dbl    = 64'hC01C000000000000;
    @(negedge clk);
    cnt    = 13'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sig16b !== exp_seq[i]) begin
        fails++;
        $display("FAIL back_to_back_N+%0d: got %h expected %h", i + 2, sig16b, exp_seq[i]);
      end
    end
  endtask

  task automatic test_counter_wrap;
    @(negedge clk);
    enable = 1'b1;
    cnt    = 13'h1FFF;
    dbl    = 64'hBFF0000000000000;
    @(negedge clk);
    cnt    = 13'd0;
    @(negedge clk);
    cnt    = 13'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (sig16b !== 16'hFFFF) begin
      fails++;
      $display("FAIL counter_wrap: got %h expected FFFF", sig16b);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    enable = 1'b0;
    cnt    = 13'd5;
    dbl    = '0;
    test_reset;
    test_latency;
    test_conversions;
    test_hold;
    test_enable_drop_inflight;
    test_reset_inflight;
    test_back_to_back;
    test_counter_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
